// File: rtl/simon_share_loader.sv
// -----------------------------------------------------------------------------
// simon_share_loader
//
// Upstream controller and serializer for the 2-share bit-serial Simon core.
// Latches two plaintext shares and two key shares, streams them LSB first into
// the core under the data_rdy phase protocol, waits for Done, and returns the
// recombined ciphertext with a one-cycle valid strobe. A RUN watchdog aborts
// a hung core so the loader always returns to IDLE.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request pulse, only honoured in IDLE
//   pt_a, pt_b   plaintext shares, packed {X,Y}
//   key_a, key_b key shares, packed {KX,KY}
//   busy         high in every state except IDLE
//   data_rdy     core phase: 0 idle/clear, 1 load pt, 2 load key, 3 run
//   data_ina/inb serial share bits to the core
//   done_in      core Done pulse
//   cipher_in    core recombined ciphertext
//   ct_out       captured ciphertext
//   ct_valid     one-cycle strobe on normal completion
//   timeout_err  one-cycle strobe on watchdog abort
// -----------------------------------------------------------------------------
module simon_share_loader #(
  parameter int LOAD_LEN    = 128,
  parameter int RUN_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] pt_a,
  input  logic [127:0] pt_b,
  input  logic [127:0] key_a,
  input  logic [127:0] key_b,
  output logic         busy,
  output logic [1:0]   data_rdy,
  output logic         data_ina,
  output logic         data_inb,
  input  logic         done_in,
  input  logic [127:0] cipher_in,
  output logic [127:0] ct_out,
  output logic         ct_valid,
  output logic         timeout_err
);

  localparam int CNT_W = $clog2(LOAD_LEN);
  localparam int WD_W  = $clog2(RUN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_LEN - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_PT,
    S_LOAD_KEY,
    S_RUN,
    S_CAPTURE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WD_W-1:0]   r_wd;
  logic [127:0]      r_pta;
  logic [127:0]      r_ptb;
  logic [127:0]      r_ka;
  logic [127:0]      r_kb;
  logic [1:0]        r_rdy;
  logic              r_ina;
  logic              r_inb;
  logic [127:0]      r_ct;
  logic              r_ct_valid;
  logic              r_timeout;
  logic              r_busy;

  state_t            w_state;
  logic [CNT_W-1:0]  w_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [WD_W-1:0]   w_wd;
  logic [1:0]        w_rdy;
  logic              w_ina;
  logic              w_inb;
  logic              w_ct_valid;
  logic              w_timeout;
  logic              w_busy;
  logic              w_latch;
  logic              w_capture;

  // r_cnt holds the index of the next bit to present. It wraps to 0 after the
  // last bit, so r_cnt == 0 inside a load state means the phase is complete.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_wd       = r_wd;
    w_rdy      = 2'd0;
    w_ina      = 1'b0;
    w_inb      = 1'b0;
    w_ct_valid = 1'b0;
    w_timeout  = 1'b0;
    w_latch    = 1'b0;
    w_capture  = 1'b0;
    w_cnt_inc  = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          // Bit 0 goes out straight from the inputs on the accepting edge,
          // since the shadow registers are only being written at that edge.
          w_latch = 1'b1;
          w_state = S_LOAD_PT;
          w_rdy   = 2'd1;
          w_ina   = pt_a[0];
          w_inb   = pt_b[0];
          w_cnt   = w_cnt_inc;
        end
      end
      S_LOAD_PT: begin
        if (r_cnt == '0) begin
          w_state = S_LOAD_KEY;
          w_rdy   = 2'd2;
          w_ina   = r_ka[0];
          w_inb   = r_kb[0];
        end else begin
          w_rdy   = 2'd1;
          w_ina   = r_pta[r_cnt];
          w_inb   = r_ptb[r_cnt];
        end
        w_cnt = w_cnt_inc;
      end
      S_LOAD_KEY: begin
        if (r_cnt == '0) begin
          w_state = S_RUN;
          w_rdy   = 2'd3;
          w_wd    = '0;
        end else begin
          w_rdy   = 2'd2;
          w_ina   = r_ka[r_cnt];
          w_inb   = r_kb[r_cnt];
          w_cnt   = w_cnt_inc;
        end
      end
      S_RUN: begin
        if (done_in) begin
          w_state    = S_CAPTURE;
          w_capture  = 1'b1;
          w_ct_valid = 1'b1;
        end else if (r_wd == WD_LAST) begin
          // This edge ends the RUN_TIMEOUT-th cycle of data_rdy = 3.
          w_state   = S_CAPTURE;
          w_timeout = 1'b1;
        end else begin
          w_rdy = 2'd3;
          w_wd  = r_wd + 1'b1;
        end
      end
      S_CAPTURE: begin
        // Second cycle of data_rdy = 0 so the core counter is cleared before
        // any following run can start.
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wd       <= '0;
      r_pta      <= '0;
      r_ptb      <= '0;
      r_ka       <= '0;
      r_kb       <= '0;
      r_rdy      <= 2'd0;
      r_ina      <= 1'b0;
      r_inb      <= 1'b0;
      r_ct       <= '0;
      r_ct_valid <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_wd       <= w_wd;
      r_rdy      <= w_rdy;
      r_ina      <= w_ina;
      r_inb      <= w_inb;
      r_ct_valid <= w_ct_valid;
      r_timeout  <= w_timeout;
      r_busy     <= w_busy;
      if (w_latch) begin
        r_pta <= pt_a;
        r_ptb <= pt_b;
        r_ka  <= key_a;
        r_kb  <= key_b;
      end
      if (w_capture) begin
        r_ct <= cipher_in;
      end
    end
  end

  assign busy        = r_busy;
  assign data_rdy    = r_rdy;
  assign data_ina    = r_ina;
  assign data_inb    = r_inb;
  assign ct_out      = r_ct;
  assign ct_valid    = r_ct_valid;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_simon_share_loader.sv
// -----------------------------------------------------------------------------
// tb_simon_share_loader
//
// Bench for simon_share_loader. A small behavioural core model shifts the
// serial bits into per-phase words and pulses done_in after a fixed number of
// run cycles. Each scenario task drives stimulus, records a per-cycle trace
// and compares against expectations derived from the phase timing rules.
// -----------------------------------------------------------------------------
module tb_simon_share_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] pt_a = '0;
  logic [127:0] pt_b = '0;
  logic [127:0] key_a = '0;
  logic [127:0] key_b = '0;
  logic         done_in = 1'b0;
  logic [127:0] cipher_in = '0;
  logic         busy;
  logic [1:0]   data_rdy;
  logic         data_ina;
  logic         data_inb;
  logic [127:0] ct_out;
  logic         ct_valid;
  logic         timeout_err;

  simon_share_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pt_a       (pt_a),
    .pt_b       (pt_b),
    .key_a      (key_a),
    .key_b      (key_b),
    .busy       (busy),
    .data_rdy   (data_rdy),
    .data_ina   (data_ina),
    .data_inb   (data_inb),
    .done_in    (done_in),
    .cipher_in  (cipher_in),
    .ct_out     (ct_out),
    .ct_valid   (ct_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Core model: Done asserted during the 136th cycle of data_rdy = 3.
  localparam int DONE_AT = 136;
  localparam int MAXTR   = 1200;
  bit           done_en = 1'b1;
  logic [127:0] m_pta, m_ptb, m_ka, m_kb;
  int           n_pt, n_key, n_run;
  logic [1:0]   prev_rdy = 2'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 2'd0;
      n_run    = 0;
      done_in  = 1'b0;
    end else begin
      if (data_rdy == 2'd1) begin
        if (prev_rdy != 2'd1) begin
          m_pta = '0; m_ptb = '0; n_pt = 0;
        end
        m_pta = {data_ina, m_pta[127:1]};
        m_ptb = {data_inb, m_ptb[127:1]};
        n_pt++;
      end
      if (data_rdy == 2'd2) begin
        if (prev_rdy != 2'd2) begin
          m_ka = '0; m_kb = '0; n_key = 0;
        end
        m_ka = {data_ina, m_ka[127:1]};
        m_kb = {data_inb, m_kb[127:1]};
        n_key++;
      end
      if (data_rdy == 2'd3) n_run++;
      else n_run = 0;
      done_in  = done_en && (data_rdy == 2'd3) && (n_run == DONE_AT);
      prev_rdy = data_rdy;
    end
  end

  // Trace: index k is the cycle following accepting edge k.
  logic [1:0] tr_rdy   [MAXTR];
  logic       tr_ina   [MAXTR];
  logic       tr_valid [MAXTR];
  logic       tr_to    [MAXTR];
  logic       tr_busy  [MAXTR];
  int         tr_len;
  bit         tr_hung;

  function automatic int n_valid();
    int c = 0;
    for (int i = 0; i < tr_len; i++) if (tr_valid[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int n_timeout();
    int c = 0;
    for (int i = 0; i < tr_len; i++) if (tr_to[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int n_rdy(input logic [1:0] v);
    int c = 0;
    for (int i = 0; i < tr_len; i++) if (tr_rdy[i] === v) c++;
    return c;
  endfunction

  function automatic int first_valid(input int from);
    for (int i = from; i < tr_len; i++) if (tr_valid[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic start_run(input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] ka, input logic [127:0] kb);
    @(negedge clk);
    pt_a = a; pt_b = b; key_a = ka; key_b = kb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic observe(input int max_cyc, input bit stop_idle,
                         input int s2_k, input logic [127:0] s2_pt);
    tr_len  = 0;
    tr_hung = stop_idle;
    for (int k = 0; k < max_cyc && k < MAXTR; k++) begin
      @(negedge clk);
      #1;
      tr_rdy[k]   = data_rdy;
      tr_ina[k]   = data_ina;
      tr_valid[k] = ct_valid;
      tr_to[k]    = timeout_err;
      tr_busy[k]  = busy;
      tr_len      = k + 1;
      if (s2_k >= 0 && k == s2_k) begin
        start = 1'b1;
        pt_a  = s2_pt;
      end else if (s2_k >= 0 && k == s2_k + 1) begin
        start = 1'b0;
      end
      if (stop_idle && !busy) begin
        tr_hung = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (data_rdy !== 2'd0) begin errors++; $display("FAIL reset_rdy: got %0d expected 0", data_rdy); end
    checks++; if ({data_ina, data_inb} !== 2'b00) begin errors++; $display("FAIL reset_din: got %b expected 00", {data_ina, data_inb}); end
    checks++; if (ct_out !== '0) begin errors++; $display("FAIL reset_ct: got %h expected 0", ct_out); end
    checks++; if ({ct_valid, timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {ct_valid, timeout_err}); end
    rst_n = 1'b1;
  endtask

  task automatic test_bit_order();
    logic [127:0] a, ka, kb;
    a  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    ka = 128'h1;
    kb = 128'h1 << 127;
    done_en   = 1'b1;
    cipher_in = rnd128();
    start_run(a, '0, ka, kb);
    observe(MAXTR, 1'b1, -1, '0);
    checks++; if (tr_hung) begin errors++; $display("FAIL bitorder_done: run did not return to idle within %0d cycles", MAXTR); end
    checks++; if (n_pt !== 128 || m_pta !== a) begin errors++; $display("FAIL bitorder_pta: got %h (%0d bits) expected %h (128 bits)", m_pta, n_pt, a); end
    checks++; if (m_ptb !== '0) begin errors++; $display("FAIL bitorder_ptb: got %h expected 0", m_ptb); end
    checks++; if (n_key !== 128 || m_ka !== ka) begin errors++; $display("FAIL bitorder_keya: got %h (%0d bits) expected %h", m_ka, n_key, ka); end
    checks++; if (m_kb !== kb) begin errors++; $display("FAIL bitorder_keyb: got %h expected %h", m_kb, kb); end
  endtask

  task automatic test_timing();
    logic [127:0] a, b, ka, kb, ct;
    int bad, exp_rdy;
    a = rnd128(); b = rnd128(); ka = rnd128(); kb = rnd128();
    ct = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
    cipher_in = ct;
    done_en   = 1'b1;
    start_run(a, b, ka, kb);
    observe(MAXTR, 1'b1, -1, '0);
    bad = 0;
    for (int k = 0; k < tr_len; k++) begin
      exp_rdy = (k < 128) ? 1 : (k < 256) ? 2 : (k < 392) ? 3 : 0;
      if (tr_rdy[k] !== 2'(exp_rdy)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL timing_rdy_seq: %0d cycles wrong phase code, expected 0", bad); end
    checks++; if (first_valid(0) != 392 || n_valid() != 1) begin errors++; $display("FAIL timing_valid: first at %0d count %0d expected at 392 count 1", first_valid(0), n_valid()); end
    checks++; if (tr_len != 394 || tr_busy[392] !== 1'b1) begin errors++; $display("FAIL timing_busy: busy fell at cycle %0d expected 393", tr_len - 1); end
    checks++; if (ct_out !== ct) begin errors++; $display("FAIL timing_ct: got %h expected %h", ct_out, ct); end
    checks++; if (m_pta !== a || m_ptb !== b || m_ka !== ka || m_kb !== kb) begin errors++; $display("FAIL timing_load: pta %h expected %h", m_pta, a); end
    checks++; if (n_timeout() != 0) begin errors++; $display("FAIL timing_to: got %0d timeout strobes expected 0", n_timeout()); end
  endtask

  task automatic test_busy_reject();
    logic [127:0] a, ct;
    int idle_bad;
    a = rnd128();
    ct = rnd128();
    cipher_in = ct;
    start_run(a, rnd128(), rnd128(), rnd128());
    observe(MAXTR, 1'b1, 49, ~a);
    checks++; if (m_pta !== a) begin errors++; $display("FAIL busy_stream: got %h expected %h", m_pta, a); end
    checks++; if (n_valid() != 1 || tr_hung) begin errors++; $display("FAIL busy_valid: got %0d strobes expected 1", n_valid()); end
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (busy !== 1'b0 || data_rdy !== 2'd0) idle_bad++;
    end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL busy_noqueue: %0d busy cycles after run, expected 0", idle_bad); end
    checks++; if (ct_out !== ct) begin errors++; $display("FAIL busy_ct: got %h expected %h", ct_out, ct); end
  endtask

  task automatic test_watchdog();
    logic [127:0] old_ct;
    old_ct    = cipher_in;
    done_en   = 1'b0;
    cipher_in = rnd128();
    start_run(rnd128(), rnd128(), rnd128(), rnd128());
    observe(MAXTR, 1'b1, -1, '0);
    checks++; if (n_rdy(2'd3) != 255) begin errors++; $display("FAIL wd_run_len: got %0d run cycles expected 255", n_rdy(2'd3)); end
    checks++; if (n_timeout() != 1 || tr_to[511] !== 1'b1) begin errors++; $display("FAIL wd_strobe: got %0d strobes expected 1 at cycle 511", n_timeout()); end
    checks++; if (n_valid() != 0) begin errors++; $display("FAIL wd_valid: got %0d valid strobes expected 0", n_valid()); end
    checks++; if (ct_out !== old_ct) begin errors++; $display("FAIL wd_ct_hold: got %h expected %h", ct_out, old_ct); end
    done_en   = 1'b1;
    cipher_in = old_ct;
  endtask

  task automatic test_reset_midload();
    logic [127:0] a, ct;
    start_run(rnd128(), rnd128(), rnd128(), rnd128());
    observe(201, 1'b0, -1, '0);
    checks++; if (tr_rdy[200] !== 2'd2) begin errors++; $display("FAIL rst_pre_phase: got %0d expected 2", tr_rdy[200]); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, data_rdy, data_ina, data_inb, ct_valid, timeout_err} !== 7'b0) begin errors++; $display("FAIL rst_async_ctl: got %b expected 0", {busy, data_rdy, data_ina, data_inb, ct_valid, timeout_err}); end
    checks++; if (ct_out !== '0) begin errors++; $display("FAIL rst_async_ct: got %h expected 0", ct_out); end
    @(negedge clk);
    rst_n = 1'b1;
    a = rnd128();
    ct = rnd128();
    cipher_in = ct;
    start_run(a, rnd128(), rnd128(), rnd128());
    observe(MAXTR, 1'b1, -1, '0);
    checks++; if (tr_rdy[0] !== 2'd1 || tr_ina[0] !== a[0]) begin errors++; $display("FAIL rst_restart_bit0: got rdy %0d bit %b expected 1 %b", tr_rdy[0], tr_ina[0], a[0]); end
    checks++; if (m_pta !== a || n_pt != 128) begin errors++; $display("FAIL rst_restart_load: got %h expected %h", m_pta, a); end
    checks++; if (n_valid() != 1 || ct_out !== ct) begin errors++; $display("FAIL rst_restart_ct: got %h (%0d strobes) expected %h", ct_out, n_valid(), ct); end
  endtask

  task automatic test_back_to_back();
    int v0, v1, zrun, min_gap, drained;
    bit seen_nz;
    cipher_in = rnd128();
    @(negedge clk);
    pt_a = rnd128(); pt_b = rnd128(); key_a = rnd128(); key_b = rnd128();
    start = 1'b1;
    @(posedge clk);
    observe(800, 1'b0, -1, '0);
    start = 1'b0;
    v0 = first_valid(0);
    v1 = (v0 >= 0) ? first_valid(v0 + 1) : -1;
    checks++; if (n_valid() != 2 || v0 != 392) begin errors++; $display("FAIL b2b_count: got %0d strobes first at %0d expected 2 first at 392", n_valid(), v0); end
    checks++; if (v1 - v0 != 394) begin errors++; $display("FAIL b2b_period: got %0d expected 394", v1 - v0); end
    min_gap = 1000; zrun = 0; seen_nz = 1'b0;
    for (int k = 0; k < tr_len; k++) begin
      if (tr_rdy[k] === 2'd0) zrun++;
      else begin
        if (seen_nz && zrun > 0 && zrun < min_gap) min_gap = zrun;
        seen_nz = 1'b1;
        zrun = 0;
      end
    end
    checks++; if (min_gap < 2 || min_gap == 1000) begin errors++; $display("FAIL b2b_gap: got min gap %0d expected at least 2", min_gap); end
    drained = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (!busy) begin drained = 1; break; end
    end
    checks++; if (drained != 1) begin errors++; $display("FAIL b2b_drain: busy stuck high, expected idle"); end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_timing();
    test_busy_reject();
    test_watchdog();
    test_reset_midload();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_share_loader.md
Name: simon_share_loader

Overview:
- Upstream controller and serializer for the 2-share bit-serial Simon core.
- Accepts two 128-bit plaintext shares and two 128-bit key shares in parallel, then drives the core's serial load/run protocol (data_rdy, data_ina, data_inb).
- Waits for the core's Done pulse, captures the recombined 128-bit cipher_out and presents it with a one-cycle valid strobe.
- Includes a run watchdog so that a hung core cannot lock the loader.

Parameters:
- LOAD_LEN, 128, cycles per serial load phase; equals the bits per 128-bit share word.
- RUN_TIMEOUT, 255, maximum RUN-state cycles to wait for done_in before aborting.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- pt_a  in  128  plaintext share A, packed {X,Y}: X = [127:64], Y = [63:0].
- pt_b  in  128  plaintext share B, same packing.
- key_a  in  128  key share A, packed {KX,KY}.
- key_b  in  128  key share B, same packing.
- busy  out  1  high in every state except IDLE.
- data_rdy  out  2  core phase code: 0 = idle/clear, 1 = load plaintext, 2 = load key, 3 = run.
- data_ina  out  1  serial bit for share A.
- data_inb  out  1  serial bit for share B.
- done_in  in  1  core Done pulse.
- cipher_in  in  128  core cipher_out.
- ct_out  out  128  captured ciphertext.
- ct_valid  out  1  one-cycle strobe; ct_out is valid while it is high.
- timeout_err  out  1  one-cycle strobe on a watchdog abort.

Behaviour:
- Reset: all outputs and registers clear asynchronously. State = IDLE, data_rdy = 0, data_ina/inb = 0, ct_out = 0, strobes = 0, bit counter = 0, watchdog = 0.
- A reset mid-operation returns to IDLE immediately. The core's counter then clears on the next edge because data_rdy = 0.
- All outputs are registered. There is no combinational path from any input to any output.

State machine:
- IDLE: data_rdy = 0.
  - On a start edge, latch pt_a, pt_b, key_a and key_b into internal 128-bit shadow shift registers.
  - Go to LOAD_PT. At that same edge, drive data_rdy = 1, data_ina = pt_a[0], data_inb = pt_b[0].
- LOAD_PT: data_rdy = 1 for exactly LOAD_LEN cycles.
  - In cycle i (0..127), data_ina = pt_a[i] and data_inb = pt_b[i], LSB first.
  - This leaves X/Y in the core equal to the packed word.
  - After bit 127, go to LOAD_KEY.
- LOAD_KEY: data_rdy = 2 for exactly LOAD_LEN cycles, with key bits in the same LSB-first order, then go to RUN.
- RUN: data_rdy = 3, data_ina/inb = 0. The watchdog counts cycles spent in RUN.
  - If done_in is sampled high: capture ct_out <= cipher_in at that edge, go to CAPTURE, and set data_rdy = 0.
  - If the watchdog reaches RUN_TIMEOUT with no done_in: go to CAPTURE without updating ct_out, and flag an abort.
- CAPTURE: one cycle with data_rdy = 0.
  - ct_valid = 1 on a normal completion; timeout_err = 1 on an abort. The two are never high together.
  - Next state is IDLE. The minimum gap of 2 cycles with data_rdy = 0 between runs guarantees the core counter clears.

Handshake and boundary rules:
- start is ignored while busy. It is not queued and the shadow inputs are not re-latched.
- A start high in the same cycle as the ct_valid strobe is ignored, because the state is CAPTURE, not IDLE.
- done_in seen outside RUN is ignored.
- Bit counter: 7 bits, wraps 127 -> 0 at the phase change. Watchdog: 8 bits, cleared on RUN entry.

Latency:
- Let start be accepted at edge 0.
- data_rdy = 1 during edges 0..127, data_rdy = 2 during edges 128..255, data_rdy = 3 from edge 256.
- With the core asserting Done at its counter value 134, done_in rises after edge 391 and is sampled at edge 392.
- ct_valid is high in the cycle after edge 392, so start-to-ct_valid is 392 cycles.

Test Plan:
- Bit order: pt_a = 128'h0123456789ABCDEF_FEDCBA9876543210, pt_b = 0, key_a = 128'h1, key_b = 128'h8000…0 -> a bench shift model mirroring the core's {X,Y} shifting reproduces pt_a and pt_b exactly after 128 cycles of data_rdy = 1, and reproduces key_a (only LSB set) and key_b (only MSB set) after 128 cycles of data_rdy = 2.
- Timing: start at edge 0, behavioural core model pulses done_in after edge 391 with cipher_in = 128'hDEADBEEF…0001 -> ct_valid high only in the cycle after edge 392, ct_out equals that value, busy low after edge 393.
- Busy rejection: a second start pulse at edge 50 with different pt_a -> the load stream is unchanged, and exactly one ct_valid is produced.
- Watchdog: done_in tied low -> data_rdy = 3 for exactly 255 cycles, then timeout_err pulses once, ct_valid stays 0 and ct_out keeps its old value.
- Reset mid-load: rst_n low during cycle 200 (LOAD_KEY) -> all outputs are 0 immediately (asynchronous); a fresh start after release reloads from bit 0.
- Back-to-back: start held high continuously -> each run's data_rdy shows at least 2 cycles of 0 between runs, and the ct_valid strobes are 394 cycles apart.
